// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port mesh switch.
// Holds the port count, the port index names and the output-arbiter
// state encoding. Ports: none (package only).
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    typedef enum logic {
        S_IDLE   = ST_IDLE,
        S_LOCKED = ST_LOCKED
    } arb_state_e;

endpackage : noc_pkg

// File: rtl/rr_priority_pick.sv
// Rotating priority picker (purely combinational).
// Picks the first set request bit searching from index ptr upward and
// wrapping around, returning the choice both one-hot and as an index.
// Ports:
//   req         - request vector, one bit per input port
//   ptr         - index of the highest-priority input
//   pick_onehot - one-hot winner, zero when req is zero
//   pick_idx    - winner index, zero when req is zero
module rr_priority_pick
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] pick_onehot,
    output logic [PTR_W-1:0]     pick_idx
);

    logic [NUM_PORTS-1:0] rot;
    logic                 found;

    // rot[0] is the request at ptr, rot[1] the one after it, and so on;
    // a fixed lowest-index-first search over rot is the rotated search.
    always_comb begin
        rot         = '0;
        found       = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rot[i] = req[(i + int'(ptr)) % NUM_PORTS];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                found    = 1'b1;
                pick_idx = PTR_W'((i + int'(ptr)) % NUM_PORTS);
            end
        end
        if (found) begin
            pick_onehot = NUM_PORTS'(1) << pick_idx;
        end
    end

endmodule : rr_priority_pick

// File: rtl/rr_output_arbiter.sv
// Per-output wormhole arbiter with round-robin fairness.
// A winner is chosen in IDLE and locked until its tail flit transfers;
// the pointer then moves just past the released owner.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - per-input "has a flit for this output"
//   tail       - per-input "current flit is a tail"
//   out_ready  - downstream can accept a flit this cycle
//   grant      - registered one-hot owner (crossbar select)
//   out_valid  - a flit is driven on the output this cycle
//   pop        - per-input transfer strobe back to the input buffers
//   busy       - registered, high while a packet is locked
module rr_output_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 out_valid,
    output logic [NUM_PORTS-1:0] pop,
    output logic                 busy
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic [NUM_PORTS-1:0] pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     owner;
    logic                 lock_ok;
    logic                 xfer;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req         (req),
        .ptr         (ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                owner = PTR_W'(i);
            end
        end
    end

    // Outputs are only meaningful with a single legal owner; anything
    // else is treated as corruption and flushed back to IDLE below.
    assign lock_ok = (state_q == S_LOCKED) && $onehot(grant_q);
    assign xfer    = lock_ok && req[owner] && out_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        out_valid = 1'b0;
        pop       = '0;
        unique case (state_q)
            S_IDLE: begin
                grant_d = pick_onehot;
                if (|req) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (!lock_ok) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else begin
                    out_valid = xfer;
                    pop       = grant_q & {NUM_PORTS{out_ready}} & req;
                    if (xfer && tail[owner]) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        ptr_d   = (owner == PTR_W'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == S_LOCKED);

endmodule : rr_output_arbiter

// File: tb/tb_rr_output_arbiter.sv
module tb_rr_output_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         out_ready;
    logic [N-1:0] grant;
    logic         out_valid;
    logic [N-1:0] pop;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: current owner (-1 = none) and priority pointer.
    int m_owner = -1;
    int m_ptr   = 0;

    rr_output_arbiter #(.NUM_PORTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .pop       (pop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model next state, evaluated from the inputs present at the edge.
    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req[c] && m_owner < 0) m_owner = c;
            end
        end else if (req[m_owner] && out_ready && tail[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] e_grant;
            logic         e_valid;
            e_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
            e_valid = (m_owner >= 0) && req[m_owner] && out_ready;
            chk("model_grant", grant, e_grant);
            chk("model_busy", N'(busy), N'(m_owner >= 0));
            chk("model_out_valid", N'(out_valid), N'(e_valid));
            chk("model_pop", pop, e_valid ? e_grant : '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t, input logic rdy);
        req       = r;
        tail      = t;
        out_ready = rdy;
        #1;
    endtask

    initial begin
        int cnt [N];
        int prev;
        int seq_err;
        logic [N-1:0] rdy_tab [7];
        logic [N-1:0] req_tab [7];
        logic [N-1:0] pop_tab [7];

        rst = 1'b1;
        drive('0, '0, 1'b0);
        tick();
        tick();
        chk_en = 1'b1;
        rst    = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_grant", grant, 5'b00000);
            chk("idle_busy", N'(busy), 5'd0);
        end

        // Two single-flit packets, ptr 0 then 3.
        drive(5'b10100, 5'b10100, 1'b1);
        tick();
        chk("sf_grant_a", grant, 5'b00100);
        chk("sf_pop_a", pop, 5'b00100);
        tick();
        drive(5'b10000, 5'b10100, 1'b1);
        chk("sf_bubble", grant, 5'b00000);
        tick();
        chk("sf_grant_b", grant, 5'b10000);
        chk("sf_pop_b", pop, 5'b10000);
        tick();
        drive('0, '0, 1'b1);
        tick();

        // Move ptr to 1 with a packet from input 0, then a 4-flit packet
        // from input 1 while everyone requests; non-owner tails ignored.
        drive(5'b00001, 5'b00001, 1'b1);
        tick();
        tick();
        drive(5'b11111, 5'b11101, 1'b1);
        tick();
        for (int f = 1; f <= 4; f++) begin
            drive(5'b11111, (f == 4) ? 5'b11111 : 5'b11101, 1'b1);
            chk("wh_grant", grant, 5'b00010);
            chk("wh_pop", pop, 5'b00010);
            tick();
        end
        chk("wh_release", grant, 5'b00000);
        tick();
        chk("wh_next_grant", grant, 5'b00100);
        tick();
        drive('0, '0, 1'b1);
        tick();

        // Same packet with stalls and a momentary empty owner buffer.
        drive(5'b00001, 5'b00001, 1'b1);
        tick();
        tick();
        drive(5'b11111, 5'b11101, 1'b1);
        tick();
        rdy_tab = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1};
        req_tab = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11101, 5'b11111, 5'b11111};
        pop_tab = '{5'b00010, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00010};
        for (int c = 0; c < 7; c++) begin
            drive(req_tab[c], (c == 6) ? 5'b11111 : 5'b11101, rdy_tab[c][0]);
            chk("stall_grant", grant, 5'b00010);
            chk("stall_pop", pop, pop_tab[c]);
            tick();
        end
        chk("stall_release", grant, 5'b00000);
        chk("stall_busy", N'(busy), 5'd0);
        tick();
        chk("stall_next_grant", grant, 5'b00100);
        tick();
        drive('0, '0, 1'b1);
        tick();

        // Everyone streams single-flit packets: strict rotation, no starvation.
        drive(5'b11111, 5'b11111, 1'b1);
        foreach (cnt[i]) cnt[i] = 0;
        prev    = -1;
        seq_err = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (pop[i]) begin
                    cnt[i]++;
                    if (prev >= 0 && i != (prev + 1) % N) seq_err++;
                    prev = i;
                end
            end
        end
        chk("rr_sequence_errors", N'(seq_err), 5'd0);
        for (int i = 0; i < N; i++) chk("rr_pops_per_input", N'(cnt[i]), 5'd5);
        drive('0, '0, 1'b1);
        tick();
        tick();

        // Reset while locked mid-packet on input 3.
        drive(5'b01000, 5'b00000, 1'b1);
        tick();
        chk("rst_lock_grant", grant, 5'b01000);
        tick();
        rst = 1'b1;
        drive(5'b11111, 5'b00000, 1'b1);
        tick();
        chk("rst_grant", grant, 5'b00000);
        chk("rst_busy", N'(busy), 5'd0);
        rst = 1'b0;
        tick();
        chk("rst_ptr0_grant", grant, 5'b00001);
        drive(5'b11111, 5'b11111, 1'b1);
        tick();

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(N'($urandom) & N'($urandom | $urandom), N'($urandom), ($urandom_range(0, 3) != 0));
            tick();
        end
        rst = 1'b0;
        drive('0, '0, 1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_output_arbiter

// File: doc/rr_output_arbiter.md
Name: rr_output_arbiter

Overview:
Per-output-port wormhole arbiter for the 5-port mesh switch. It arbitrates between the five input ports requesting one output port, using round-robin fairness with packet locking. Its registered one-hot grant drives the select of that output's 5:1 one-hot crossbar mux. It holds the grant from head flit to tail flit, and returns per-input pop strobes to the input buffers.

Parameters:
NUM_PORTS, 5, number of requesting input ports; sets the req/tail/grant/pop width.

Ports:
clk  input  1  switch clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  NUM_PORTS  bit i: input i holds a flit routed to this output
tail  input  NUM_PORTS  bit i: flit currently at input i is a tail (single-flit packet = head+tail)
out_ready  input  1  downstream (neighbour buffer) can accept a flit this cycle
grant  output  NUM_PORTS  registered one-hot (or zero) owner; wired to the crossbar mux select
out_valid  output  1  combinational; a flit is driven on the output this cycle
pop  output  NUM_PORTS  combinational; bit i pulses when input i's flit is transferred
busy  output  1  registered; high while in LOCKED

Behaviour:
- Reset (rst=1 at clk edge): grant=0, busy=0, state=IDLE, priority pointer ptr=0 (input 0 highest). out_valid and pop are 0 while grant=0.
- States: IDLE, LOCKED.
- Priority pointer and search:
  - ptr is an index in 0..NUM_PORTS-1.
  - Search order is ptr, ptr+1, ..., wrapping modulo NUM_PORTS.
- IDLE:
  - If req != 0: pick the first set req bit in search order. Next edge: grant = onehot(pick), busy=1, state=LOCKED.
  - If req == 0: stay in IDLE, grant=0.
  - Latency from req asserted to grant visible is 1 cycle. No flit moves in the grant cycle.
- LOCKED, owner g:
  - Transfer condition: xfer = req[g] & out_ready.
  - out_valid = xfer; pop = grant & {NUM_PORTS{out_ready}} & req.
  - On xfer & tail[g], next edge: grant=0, busy=0, ptr=(g+1) mod NUM_PORTS, state=IDLE. The next packet is granted no earlier than 2 cycles after the tail transfer (one bubble; intentional).
  - On xfer & ~tail[g]: hold grant (body flit).
  - out_ready=0: hold grant; out_valid=0, pop=0.
  - req[g]=0 mid-packet (input buffer momentarily empty): hold grant (wormhole lock). Other requesters are ignored until the owner's tail transfers.
- Grant is never multi-hot. Any illegal state or multi-hot grant returns to IDLE with grant=0.
- ptr advances only on tail release, never in IDLE.
- Reset mid-packet: lock dropped, grant=0, ptr=0. Upstream flushing is outside this block.
- tail bits of non-owners are ignored.

Decomposition:
- Shared package noc_pkg:
  - NUM_PORTS=5.
  - Port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - State encoding localparams ST_IDLE and ST_LOCKED.
- One sub-module, rr_priority_pick (combinational): inputs req and ptr; outputs one-hot pick and its index. It rotates req by ptr, applies a fixed priority encoder, then rotates back.
- The top level holds the FSM, ptr, and grant registers.

Test Plan:
- Reset then req=5'b00000 for 5 cycles -> grant=0, out_valid=0, busy=0 throughout.
- req=5'b10100, ptr=0, single-flit (tail=5'b10100), out_ready=1 -> grant=5'b00100 at cycle 1, pop=5'b00100 at cycle 1, release, ptr=3. Next grant=5'b10000 at cycle 3, pop=5'b10000.
- 4-flit packet from input 1 (tail on 4th flit) with req=5'b11111 constant -> grant=5'b00010 for exactly 4 transfer cycles, other pops 0, then ptr=2 and next grant=5'b00100.
- Same packet with out_ready low on cycles 2-3 and req[1] low on cycle 5 -> grant held, out_valid=0 and pop=0 on those cycles; tail still releases after the 4th actual transfer.
- All five inputs continuously sending single-flit packets -> grant sequence 0,1,2,3,4,0,... with each input popped once per 10 cycles (no starvation).
- rst asserted while LOCKED on input 3 mid-packet -> next edge grant=0, busy=0. With req=5'b11111 after reset, grant=5'b00001 (ptr back to 0).
